mv_tile_ctrl: RTL and testbench



---
 rtl/mv_tile_pkg.sv | 20 ++
 rtl/mv_mac_lane.sv | 37 +++
 rtl/mv_tile_ctrl.sv | 160 ++++++++++++++++
 tb/tb_mv_tile_ctrl.sv | 329 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mv_tile_pkg.sv
// Shared types and sizing helpers for the matrix-vector tile controller.
package mv_tile_pkg;

    typedef enum logic [2:0] {
        IDLE,
        LOADV,
        CALC,
        DRAIN,
        WRITE,
        DONE
    } state_e;

    function automatic int clog2_min1(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

    localparam int N_PE_DFLT = 4;
    localparam int ROW_W     = clog2_min1(N_PE_DFLT);

endpackage

// File: rtl/mv_mac_lane.sv
// One MAC lane: acc += a*b modulo 2^DATA_W, with a synchronous clear.
module mv_mac_lane #(
    parameter int DATA_W = 32
) (
    input  logic              aclk,
    input  logic              aresetn,
    input  logic              clear,
    input  logic              en,
    input  logic [DATA_W-1:0] a,
    input  logic [DATA_W-1:0] b,
    output logic [DATA_W-1:0] acc
);

    logic [DATA_W-1:0] acc_q;
    logic [DATA_W-1:0] prod;

    // Low half of a signed product equals the low half of the unsigned one.
    assign prod = a * b;

    // acc shows the value the lane will hold after this edge, so the
    // result mux can pick up the final column without waiting a cycle.
    always_comb begin
        acc = acc_q;
        if (clear)
            acc = '0;
        else if (en)
            acc = acc_q + prod;
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn)
            acc_q <= '0;
        else
            acc_q <= acc;
    end

endmodule

// File: rtl/mv_tile_ctrl.sv
// Matrix-vector controller: y = A*x (or y += A*x) over N_PE lanes, K columns,
// streamed from one wide read port, results written out one row per cycle.
module mv_tile_ctrl
    import mv_tile_pkg::*;
#(
    parameter int N_PE    = 4,
    parameter int VEC_LEN = 16,
    parameter int DATA_W  = 32,
    parameter int ADDR_W  = 13
) (
    input  logic                         aclk,
    input  logic                         aresetn,
    input  logic                         start,
    input  logic                         accum,
    output logic                         busy,
    output logic                         done,
    output logic                         rden,
    output logic [ADDR_W-1:0]            rdaddr,
    input  logic [N_PE*DATA_W-1:0]       rddata,
    output logic                         wren,
    output logic [clog2_min1(N_PE)-1:0]  wraddr,
    output logic [DATA_W-1:0]            wrdata
);

    localparam int RW = clog2_min1(N_PE);
    localparam int VW = clog2_min1(VEC_LEN);
    localparam int CW = clog2_min1((VEC_LEN > N_PE) ? VEC_LEN : N_PE);
    localparam logic [CW-1:0]     K_LAST = CW'(VEC_LEN - 1);
    localparam logic [CW-1:0]     N_LAST = CW'(N_PE - 1);
    localparam logic [ADDR_W-1:0] K_ADDR = ADDR_W'(VEC_LEN);

    state_e            state, state_nxt;
    logic [CW-1:0]     cnt, cnt_nxt;
    logic              busy_nxt, done_nxt, rden_nxt, wren_nxt, clear_acc;
    logic [ADDR_W-1:0] rdaddr_nxt;
    logic [RW-1:0]     wraddr_nxt, row_inc;
    logic [DATA_W-1:0] wrdata_nxt;

    logic              rd_vld_q, rd_col_q, mac_en;
    logic [VW-1:0]     rd_idx_q;
    logic [DATA_W-1:0] vreg [VEC_LEN];
    logic [N_PE-1:0][DATA_W-1:0] lane_acc;

    assign row_inc = wraddr + RW'(1);
    assign mac_en  = rd_vld_q & rd_col_q;

    always_comb begin
        state_nxt  = state;
        cnt_nxt    = cnt;
        busy_nxt   = busy;
        done_nxt   = 1'b0;
        rden_nxt   = 1'b0;
        rdaddr_nxt = rdaddr;
        wren_nxt   = 1'b0;
        wraddr_nxt = wraddr;
        wrdata_nxt = wrdata;
        clear_acc  = 1'b0;
        case (state)
            IDLE: if (start) begin
                state_nxt  = LOADV;
                cnt_nxt    = K_LAST;
                busy_nxt   = 1'b1;
                rden_nxt   = 1'b1;
                rdaddr_nxt = '0;
                clear_acc  = !accum;
            end
            LOADV: begin
                rden_nxt   = 1'b1;
                rdaddr_nxt = rdaddr + ADDR_W'(1);
                if (cnt == '0) begin
                    state_nxt = CALC;
                    cnt_nxt   = K_LAST;
                end else begin
                    cnt_nxt = cnt - CW'(1);
                end
            end
            CALC: if (cnt == '0) begin
                state_nxt = DRAIN;
            end else begin
                rden_nxt   = 1'b1;
                rdaddr_nxt = rdaddr + ADDR_W'(1);
                cnt_nxt    = cnt - CW'(1);
            end
            DRAIN: begin
                state_nxt  = WRITE;
                cnt_nxt    = N_LAST;
                wren_nxt   = 1'b1;
                wraddr_nxt = '0;
                wrdata_nxt = lane_acc[0];
            end
            WRITE: if (cnt == '0) begin
                state_nxt = DONE;
                done_nxt  = 1'b1;
            end else begin
                wren_nxt   = 1'b1;
                wraddr_nxt = row_inc;
                wrdata_nxt = lane_acc[row_inc];
                cnt_nxt    = cnt - CW'(1);
            end
            DONE: begin
                state_nxt = IDLE;
                busy_nxt  = 1'b0;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            state  <= IDLE;
            cnt    <= '0;
            busy   <= 1'b0;
            done   <= 1'b0;
            rden   <= 1'b0;
            rdaddr <= '0;
            wren   <= 1'b0;
            wraddr <= '0;
            wrdata <= '0;
        end else begin
            state  <= state_nxt;
            cnt    <= cnt_nxt;
            busy   <= busy_nxt;
            done   <= done_nxt;
            rden   <= rden_nxt;
            rdaddr <= rdaddr_nxt;
            wren   <= wren_nxt;
            wraddr <= wraddr_nxt;
            wrdata <= wrdata_nxt;
        end
    end

    // Tag each read so the returning data (one cycle later) knows where it goes.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            rd_vld_q <= 1'b0;
            rd_col_q <= 1'b0;
            rd_idx_q <= '0;
            for (int c = 0; c < VEC_LEN; c++) vreg[c] <= '0;
        end else begin
            rd_vld_q <= rden;
            rd_col_q <= (rdaddr >= K_ADDR);
            rd_idx_q <= (rdaddr >= K_ADDR) ? VW'(rdaddr - K_ADDR) : VW'(rdaddr);
            if (rd_vld_q && !rd_col_q)
                vreg[rd_idx_q] <= rddata[DATA_W-1:0];
        end
    end

    for (genvar i = 0; i < N_PE; i++) begin : g_lane
        mv_mac_lane #(.DATA_W(DATA_W)) u_lane (
            .aclk    (aclk),
            .aresetn (aresetn),
            .clear   (clear_acc),
            .en      (mac_en),
            .a       (rddata[i*DATA_W +: DATA_W]),
            .b       (vreg[rd_idx_q]),
            .acc     (lane_acc[i])
        );
    end

endmodule

// File: tb/tb_mv_tile_ctrl.sv
// Bench for mv_tile_ctrl: three sizes (4x4, 8x16, 1x1) against a y=A*x model.
module tb_mv_tile_ctrl;

    logic aclk = 1'b0;
    logic aresetn = 1'b0;
    always #5 aclk = ~aclk;

    int cyc = 0;
    always @(posedge aclk) cyc <= cyc + 1;

    int checks = 0;
    int failures = 0;

    logic start_v [3];
    logic accum_v [3];

    // instance 0: N_PE=4 K=4 ; instance 1: N_PE=8 K=16 ; instance 2: N_PE=1 K=1
    logic         busy_a, done_a, rden_a, wren_a;
    logic [2:0]   rdaddr_a;
    logic [127:0] rddata_a;
    logic [1:0]   wraddr_a;
    logic [31:0]  wrdata_a;
    logic         busy_b, done_b, rden_b, wren_b;
    logic [4:0]   rdaddr_b;
    logic [255:0] rddata_b;
    logic [2:0]   wraddr_b;
    logic [31:0]  wrdata_b;
    logic         busy_c, done_c, rden_c, wren_c;
    logic [0:0]   rdaddr_c;
    logic [31:0]  rddata_c;
    logic [0:0]   wraddr_c;
    logic [31:0]  wrdata_c;

    mv_tile_ctrl #(.N_PE(4), .VEC_LEN(4), .DATA_W(32), .ADDR_W(3)) dut_a (
        .aclk(aclk), .aresetn(aresetn), .start(start_v[0]), .accum(accum_v[0]),
        .busy(busy_a), .done(done_a), .rden(rden_a), .rdaddr(rdaddr_a), .rddata(rddata_a),
        .wren(wren_a), .wraddr(wraddr_a), .wrdata(wrdata_a));
    mv_tile_ctrl #(.N_PE(8), .VEC_LEN(16), .DATA_W(32), .ADDR_W(5)) dut_b (
        .aclk(aclk), .aresetn(aresetn), .start(start_v[1]), .accum(accum_v[1]),
        .busy(busy_b), .done(done_b), .rden(rden_b), .rdaddr(rdaddr_b), .rddata(rddata_b),
        .wren(wren_b), .wraddr(wraddr_b), .wrdata(wrdata_b));
    mv_tile_ctrl #(.N_PE(1), .VEC_LEN(1), .DATA_W(32), .ADDR_W(1)) dut_c (
        .aclk(aclk), .aresetn(aresetn), .start(start_v[2]), .accum(accum_v[2]),
        .busy(busy_c), .done(done_c), .rden(rden_c), .rdaddr(rdaddr_c), .rddata(rddata_c),
        .wren(wren_c), .wraddr(wraddr_c), .wrdata(wrdata_c));

    // Memories: data returns one cycle after rden; random junk otherwise.
    logic [127:0] mem_a [8];
    logic [255:0] mem_b [32];
    logic [31:0]  mem_c [2];

    always @(posedge aclk) begin
        for (int i = 0; i < 4; i++) rddata_a[i*32 +: 32] <= $urandom;
        for (int i = 0; i < 8; i++) rddata_b[i*32 +: 32] <= $urandom;
        rddata_c <= $urandom;
        if (rden_a) rddata_a <= mem_a[rdaddr_a];
        if (rden_b) rddata_b <= mem_b[rdaddr_b];
        if (rden_c) rddata_c <= mem_c[rdaddr_c];
    end

    // Reference data and per-instance accumulator model.
    int mA [8][16];
    int mx [16];
    int macc [3][8];

    // Monitor of the selected instance.
    int          sel = 0;
    logic        wren_s, done_s, rden_s, busy_s;
    int          wraddr_s;
    logic [31:0] wrdata_s;
    always_comb begin
        wren_s = 1'b0; done_s = 1'b0; rden_s = 1'b0; busy_s = 1'b0;
        wraddr_s = 0; wrdata_s = '0;
        case (sel)
            0: begin wren_s = wren_a; done_s = done_a; rden_s = rden_a; busy_s = busy_a;
                     wraddr_s = int'(wraddr_a); wrdata_s = wrdata_a; end
            1: begin wren_s = wren_b; done_s = done_b; rden_s = rden_b; busy_s = busy_b;
                     wraddr_s = int'(wraddr_b); wrdata_s = wrdata_b; end
            default: begin wren_s = wren_c; done_s = done_c; rden_s = rden_c; busy_s = busy_c;
                     wraddr_s = int'(wraddr_c); wrdata_s = wrdata_c; end
        endcase
    end

    int          wq_addr [$];
    logic [31:0] wq_data [$];
    int          wq_cyc  [$];
    int          rq [$];
    int          brise [$];
    int          bfall [$];
    int          done_cnt = 0;
    int          done_cyc = -1;
    logic        rden_prev = 1'b0;
    logic        busy_prev = 1'b0;

    always @(negedge aclk) begin
        if (wren_s) begin
            wq_addr.push_back(wraddr_s);
            wq_data.push_back(wrdata_s);
            wq_cyc.push_back(cyc);
        end
        if (done_s) begin
            done_cnt++;
            done_cyc = cyc;
        end
        if (rden_s && !rden_prev) rq.push_back(cyc);
        if (busy_s && !busy_prev) brise.push_back(cyc);
        if (!busy_s && busy_prev) bfall.push_back(cyc);
        rden_prev = rden_s;
        busy_prev = busy_s;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic clr_mon();
        wq_addr.delete(); wq_data.delete(); wq_cyc.delete();
        rq.delete(); brise.delete(); bfall.delete();
        done_cnt = 0; done_cyc = -1;
    endtask

    task automatic clr_data();
        for (int i = 0; i < 8; i++) for (int c = 0; c < 16; c++) mA[i][c] = 0;
        for (int c = 0; c < 16; c++) mx[c] = 0;
    endtask

    task automatic rand_data();
        for (int i = 0; i < 8; i++) for (int c = 0; c < 16; c++) mA[i][c] = int'($urandom);
        for (int c = 0; c < 16; c++) mx[c] = int'($urandom);
    endtask

    task automatic load_mem(input int inst);
        case (inst)
            0: for (int c = 0; c < 4; c++)
                for (int i = 0; i < 4; i++) begin
                    mem_a[c][i*32 +: 32]   = (i == 0) ? mx[c] : int'($urandom);
                    mem_a[4+c][i*32 +: 32] = mA[i][c];
                end
            1: for (int c = 0; c < 16; c++)
                for (int i = 0; i < 8; i++) begin
                    mem_b[c][i*32 +: 32]    = (i == 0) ? mx[c] : int'($urandom);
                    mem_b[16+c][i*32 +: 32] = mA[i][c];
                end
            default: begin
                mem_c[0] = mx[0];
                mem_c[1] = mA[0][0];
            end
        endcase
    endtask

    // y_i = sum_c A[i][c]*x[c], optionally added to the previous result; int wraps mod 2^32.
    task automatic model_op(input int inst, input int n, input int k, input bit acc_m);
        for (int i = 0; i < n; i++) begin
            int s = 0;
            for (int c = 0; c < k; c++) s += mA[i][c] * mx[c];
            macc[inst][i] = (acc_m ? macc[inst][i] : 0) + s;
        end
    endtask

    task automatic wait_done(input int target, input string nm);
        int n = 0;
        while (done_cnt < target && n < 300) begin
            @(posedge aclk);
            n++;
        end
        chk({nm, "_timeout"}, 32'(n < 300), 32'd1);
    endtask

    task automatic run_op(input int inst, input bit acc_m, input string nm, output int t);
        clr_mon();
        sel = inst;
        @(posedge aclk); #1;
        start_v[inst] = 1'b1; accum_v[inst] = acc_m; t = cyc;
        @(posedge aclk); #1;
        start_v[inst] = 1'b0; accum_v[inst] = 1'($urandom);
        wait_done(1, nm);
        repeat (3) @(posedge aclk);
    endtask

    task automatic check_op(input int inst, input int n, input int k, input bit acc_m,
                            input int t, input string nm);
        model_op(inst, n, k, acc_m);
        chk({nm, "_nwr"}, wq_data.size(), n);
        for (int i = 0; i < n; i++) if (i < wq_data.size()) begin
            chk($sformatf("%s_addr%0d", nm, i), wq_addr[i], i);
            chk($sformatf("%s_data%0d", nm, i), wq_data[i], macc[inst][i]);
            chk($sformatf("%s_wcyc%0d", nm, i), wq_cyc[i], t + 2*k + 2 + i);
        end
        chk({nm, "_donecyc"}, done_cyc, t + 2*k + n + 2);
        chk({nm, "_donecnt"}, done_cnt, 1);
        chk({nm, "_rdfirst"}, (rq.size() > 0) ? rq[0] : -1, t + 1);
        chk({nm, "_busyrise"}, (brise.size() > 0) ? brise[0] : -1, t + 1);
        chk({nm, "_busyfall"}, (bfall.size() > 0) ? bfall[0] : -1, done_cyc + 1);
    endtask

    task automatic chk_zero_a(input string nm);
        chk({nm, "_busy"}, busy_a, 0);
        chk({nm, "_done"}, done_a, 0);
        chk({nm, "_rden"}, rden_a, 0);
        chk({nm, "_rdaddr"}, rdaddr_a, 0);
        chk({nm, "_wren"}, wren_a, 0);
        chk({nm, "_wraddr"}, wraddr_a, 0);
        chk({nm, "_wrdata"}, wrdata_a, 0);
    endtask

    task automatic set_ident(input int n, input int x0);
        clr_data();
        for (int i = 0; i < n; i++) begin
            mA[i][i] = 1;
            mx[i] = x0 + i;
        end
    endtask

    initial begin
        int t, d;
        for (int i = 0; i < 3; i++) begin
            start_v[i] = 1'b0; accum_v[i] = 1'b0;
            for (int r = 0; r < 8; r++) macc[i][r] = 0;
        end
        clr_data();
        #12;
        chk_zero_a("rst");
        chk("rst_b_busy", {busy_b, rden_b, wren_b, done_b}, 0);
        chk("rst_c_busy", {busy_c, rden_c, wren_c, done_c}, 0);
        @(posedge aclk); #1 aresetn = 1'b1;
        repeat (2) @(posedge aclk);

        // identity, then accumulate, then clear again
        set_ident(4, 1); load_mem(0);
        run_op(0, 1'b0, "ident", t);  check_op(0, 4, 4, 1'b0, t, "ident");
        run_op(0, 1'b1, "accum", t);  check_op(0, 4, 4, 1'b1, t, "accum");
        run_op(0, 1'b0, "reclr", t);  check_op(0, 4, 4, 1'b0, t, "reclr");

        // all -1 times [1,2,3,4] -> -10 in every lane
        clr_data();
        for (int i = 0; i < 4; i++) begin
            mx[i] = i + 1;
            for (int c = 0; c < 4; c++) mA[i][c] = -1;
        end
        load_mem(0);
        run_op(0, 1'b0, "neg", t);  check_op(0, 4, 4, 1'b0, t, "neg");
        chk("neg_lane0", wq_data.size() > 0 ? wq_data[0] : 32'h0, 32'hFFFF_FFF6);

        // 0x40000000 * 2 wraps to 0x80000000
        clr_data(); mA[0][0] = 32'h4000_0000; mx[0] = 2; load_mem(0);
        run_op(0, 1'b0, "wrap", t);  check_op(0, 4, 4, 1'b0, t, "wrap");
        chk("wrap_lane0", wq_data.size() > 0 ? wq_data[0] : 32'h0, 32'h8000_0000);

        // start pulsed during CALC (with accum=0) must be ignored
        set_ident(4, 1); load_mem(0);
        clr_mon(); sel = 0;
        @(posedge aclk); #1 start_v[0] = 1'b1; accum_v[0] = 1'b1; t = cyc;
        @(posedge aclk); #1 start_v[0] = 1'b0;
        repeat (5) @(posedge aclk);
        #1 start_v[0] = 1'b1; accum_v[0] = 1'b0;
        @(posedge aclk); #1 start_v[0] = 1'b0;
        wait_done(1, "stray");
        repeat (20) @(posedge aclk);
        check_op(0, 4, 4, 1'b1, t, "stray");

        // start held high: next op accepted on the IDLE cycle after DONE
        set_ident(4, 1); load_mem(0);
        clr_mon(); sel = 0;
        @(posedge aclk); #1 start_v[0] = 1'b1; accum_v[0] = 1'b0; t = cyc;
        wait_done(1, "held1");
        d = done_cyc;
        begin
            int n = 0;
            while (rq.size() < 2 && n < 20) begin @(posedge aclk); n++; end
        end
        #1 start_v[0] = 1'b0;
        chk("held_rd2", (rq.size() > 1) ? rq[1] : -1, d + 2);
        wait_done(2, "held2");
        repeat (3) @(posedge aclk);
        chk("held_done2", done_cyc, d + 1 + 2*4 + 4 + 2);
        chk("held_nwr", wq_data.size(), 8);
        model_op(0, 4, 4, 1'b0);
        for (int i = 0; i < 4; i++)
            if (i + 4 < wq_data.size())
                chk($sformatf("held_data%0d", i), wq_data[i+4], macc[0][i]);

        // reset in the middle of CALC
        clr_mon(); sel = 0;
        @(posedge aclk); #1 start_v[0] = 1'b1; accum_v[0] = 1'b1; t = cyc;
        @(posedge aclk); #1 start_v[0] = 1'b0;
        repeat (5) @(posedge aclk);
        #1 aresetn = 1'b0;
        #1 chk_zero_a("midrst");
        for (int i = 0; i < 3; i++) for (int r = 0; r < 8; r++) macc[i][r] = 0;
        repeat (2) @(posedge aclk);
        #1 aresetn = 1'b1;
        clr_mon();
        repeat (8) @(posedge aclk);
        chk("postrst_nwr", wq_data.size(), 0);
        chk("postrst_done", done_cnt, 0);
        set_ident(4, 5); load_mem(0);
        run_op(0, 1'b1, "rstacc", t);  check_op(0, 4, 4, 1'b1, t, "rstacc");

        // random 4x4 operations with random accumulate
        for (int r = 0; r < 3; r++) begin
            bit am;
            am = 1'($urandom);
            rand_data(); load_mem(0);
            run_op(0, am, $sformatf("rnd%0d", r), t);
            check_op(0, 4, 4, am, t, $sformatf("rnd%0d", r));
        end

        // N_PE=1, K=1: 7 * -3
        clr_data(); mA[0][0] = 7; mx[0] = -3; load_mem(2);
        run_op(2, 1'b0, "tiny", t);  check_op(2, 1, 1, 1'b0, t, "tiny");
        chk("tiny_val", wq_data.size() > 0 ? wq_data[0] : 32'h0, 32'hFFFF_FFEB);
        rand_data(); load_mem(2);
        run_op(2, 1'b1, "tinyacc", t);  check_op(2, 1, 1, 1'b1, t, "tinyacc");

        // N_PE=8, K=16 random
        rand_data(); load_mem(1);
        run_op(1, 1'b0, "big0", t);  check_op(1, 8, 16, 1'b0, t, "big0");
        rand_data(); load_mem(1);
        run_op(1, 1'b1, "big1", t);  check_op(1, 8, 16, 1'b1, t, "big1");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
